// File: rtl/osd_pkg.sv
// Shared constants and types for the OSD character-RAM writer.
package osd_pkg;

  localparam int unsigned SCREEN_COLS = 48;
  localparam int unsigned SCREEN_ROWS = 32;
  localparam int unsigned OSD_CELLS   = SCREEN_COLS * SCREEN_ROWS;
  localparam int unsigned ADDR_W      = 11;
  localparam int unsigned TIMER_W     = 10;
  localparam int unsigned ROW_W       = 5;
  localparam int unsigned COL_W       = 6;

  typedef enum logic [1:0] {
    OSD_CLEAR  = 2'd0,
    OSD_SETPOS = 2'd1,
    OSD_PUTC   = 2'd2,
    OSD_SHOW   = 2'd3
  } osd_op_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // row*48 + col as two shifts and adds; max 1535 fits ADDR_W.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return (ADDR_W'(row) << 5) + (ADDR_W'(row) << 4) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/osd_frame_timer.sv
// Frame-count timer: decrements on vblank rising edges, drives osd_active.
module osd_frame_timer
  import osd_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               vblank_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               active_o
);

  logic               vblank_q;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               active_q;
  logic               vb_rise;

  assign vb_rise = vblank_i && !vblank_q;

  // A load in the same cycle as a vblank edge takes priority over the decrement.
  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = load_val_i;
    end else if (vb_rise && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vblank_q <= 1'b0;
      timer_q  <= '0;
      active_q <= 1'b0;
    end else begin
      vblank_q <= vblank_i;
      timer_q  <= timer_d;
      active_q <= (timer_q != '0);
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/osd_text_writer.sv
// Command-driven writer for the OSD character RAM (port A) plus display timer.
module osd_text_writer
  import osd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [10:0]       cmd_arg,
  output logic [ADDR_W-1:0] addr_a,
  output logic [7:0]        data_a,
  output logic              we_a,
  output logic              osd_active,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              show_load;
  osd_op_t           op;

  assign op        = osd_op_t'(cmd_op);
  assign cmd_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = 1'b0;
    busy_d    = 1'b0;
    show_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          unique case (op)
            OSD_CLEAR: begin
              state_d = ST_CLEAR;
              addr_d  = '0;
              data_d  = cmd_arg[7:0];
              we_d    = 1'b1;
              busy_d  = 1'b1;
              row_d   = '0;
              col_d   = '0;
            end
            OSD_SETPOS: begin
              row_d = cmd_arg[10:6];
              col_d = (cmd_arg[5:0] > COL_W'(SCREEN_COLS - 1)) ? COL_W'(SCREEN_COLS - 1)
                                                                : cmd_arg[5:0];
            end
            OSD_PUTC: begin
              we_d   = 1'b1;
              addr_d = cell_addr(row_q, col_q);
              data_d = cmd_arg[7:0];
              if (col_q == COL_W'(SCREEN_COLS - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(SCREEN_ROWS - 1)) ? '0 : row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            OSD_SHOW: begin
              show_load = 1'b1;
            end
          endcase
        end
      end
      ST_CLEAR: begin
        if (addr_q == ADDR_W'(OSD_CELLS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          addr_d = addr_q + 1'b1;
          we_d   = 1'b1;
          busy_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
    end
  end

  osd_frame_timer u_timer (
    .clk_i      (clk),
    .rst_n_i    (reset_n),
    .vblank_i   (vblank),
    .load_i     (show_load),
    .load_val_i (cmd_arg[TIMER_W-1:0]),
    .active_o   (osd_active)
  );

  assign addr_a = addr_q;
  assign data_a = data_q;
  assign we_a   = we_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_osd_text_writer.sv
// Scoreboard bench for osd_text_writer: RAM writes checked against a cursor model.
module tb_osd_text_writer;
  import osd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vblank;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [10:0] cmd_arg;
  logic [ADDR_W-1:0] addr_a;
  logic [7:0]  data_a;
  logic        we_a;
  logic        osd_active;
  logic        busy;

  osd_text_writer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vblank     (vblank),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .addr_a     (addr_a),
    .data_a     (data_a),
    .we_a       (we_a),
    .osd_active (osd_active),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
    int busy;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  pos = 0;          // model cursor as linear cell index
  int  last_addr = -1;
  int  last_data = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (reset_n === 1'b1 && we_a === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_write: got addr %0d data %0d expected no write", addr_a, data_a);
      end else begin
        e = sb.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("wr_addr", addr_a, e.addr);
        chk("wr_data", data_a, e.data);
        chk("wr_busy", busy, e.busy);
      end
      last_addr = addr_a;
      last_data = data_a;
    end
  end

  task automatic model(input logic [1:0] op, input logic [10:0] arg, input int acc);
    int r;
    int c;
    case (op)
      2'd0: begin
        for (int unsigned i = 0; i < OSD_CELLS; i++)
          sb.push_back('{cyc: acc + 1 + int'(i), addr: int'(i), data: int'(arg[7:0]), busy: 1});
        pos = 0;
      end
      2'd1: begin
        r = int'(arg[10:6]);
        c = int'(arg[5:0]);
        if (c > 47) c = 47;
        pos = r * 48 + c;
      end
      2'd2: begin
        sb.push_back('{cyc: acc + 1, addr: pos, data: int'(arg[7:0]), busy: 0});
        pos = (pos + 1) % 1536;
      end
      default: ;
    endcase
  endtask

  task automatic send(input logic [1:0] op, input logic [10:0] arg, output int acc);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!ok && n < 3000) begin
      if (cmd_ready === 1'b1) ok = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 3000 cycles");
      cmd_valid = 1'b0;
      acc = -1;
    end else begin
      acc = cyc;
      model(op, arg, acc);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse(input int hold);
    @(negedge clk);
    vblank = 1'b1;
    repeat (hold) @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int r;
    reset_n   = 1'b0;
    vblank    = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", we_a, 0);
    chk("rst_active", osd_active, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", cmd_ready, 1);
    chk("rel_we", we_a, 0);

    // CLEAR with a PUTC queued behind it
    send(2'd0, 11'h020, a0);
    send(2'd2, 11'h05A, a1);
    chk("putc_after_clear_accept", a1, a0 + 1537);
    drain();

    // row 2 col 46 then wrap into row 3
    send(2'd1, 11'((2 << 6) | 46), a0);
    send(2'd2, 11'h041, a0);
    send(2'd2, 11'h042, a0);
    send(2'd2, 11'h043, a0);
    drain();
    chk("abc_last_addr", last_addr, 144);
    chk("abc_last_data", last_data, 8'h43);
    send(2'd2, 11'h044, a0);
    drain();
    chk("cursor_3_1", last_addr, 145);

    send(2'd1, 11'((31 << 6) | 47), a0);
    send(2'd2, 11'h058, a0);
    drain();
    chk("last_cell", last_addr, 1535);
    send(2'd2, 11'h059, a0);
    drain();
    chk("wrap_to_zero", last_addr, 0);
    send(2'd1, 11'(60), a0);
    send(2'd2, 11'h061, a0);
    drain();
    chk("col_saturate", last_addr, 47);

    // randomized cursor/write traffic
    for (int unsigned i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      send(2'd2, 11'($urandom), a0);
      else if (r < 9) send(2'd1, 11'($urandom), a0);
      else            repeat ($urandom_range(1, 3)) @(posedge clk);
    end
    drain();

    // SHOW 3 over three vblank edges, each held high several cycles
    send(2'd3, 11'd3, a0);
    @(posedge clk);
    #1;
    chk("show3_active", osd_active, 1);
    pulse(4);
    pulse(4);
    chk("show3_after2", osd_active, 1);
    @(negedge clk);
    vblank = 1'b1;
    @(posedge clk);
    #1;
    chk("show3_edge3_same", osd_active, 1);
    @(posedge clk);
    #1;
    chk("show3_drop", osd_active, 0);
    @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);

    // SHOW 5 coinciding with a vblank edge: load wins
    @(negedge clk);
    chk("show5_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    cmd_arg   = 11'd5;
    vblank    = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    repeat (4) pulse(2);
    chk("show5_after4", osd_active, 1);
    pulse(2);
    chk("show5_after5", osd_active, 0);

    // SHOW 0 cancels a running timer
    send(2'd3, 11'd20, a0);
    repeat (2) @(posedge clk);
    #1;
    chk("show20_active", osd_active, 1);
    send(2'd3, 11'd0, a0);
    chk("show0_n1", osd_active, 1);
    @(posedge clk);
    #1;
    chk("show0_n2", osd_active, 0);

    // async reset in the middle of a CLEAR
    send(2'd3, 11'd10, a0);
    send(2'd0, 11'h033, a0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("mid_clear_we", we_a, 1);
    chk("mid_clear_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_we", we_a, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", addr_a, 0);
    chk("arst_data", data_a, 0);
    chk("arst_active", osd_active, 0);
    chk("arst_ready", cmd_ready, 1);
    sb.delete();
    pos = 0;
    @(negedge clk);
    reset_n = 1'b1;
    send(2'd2, 11'h077, a0);
    drain();
    chk("post_rst_addr", last_addr, 0);
    chk("post_rst_data", last_data, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/osd_text_writer.md
Name: osd_text_writer

Overview:
Write-side companion of the OSD overlay. It fills the OSD character RAM (write port A, 48x32 cells, address = row*48 + col) from a command stream issued by the core/APF control logic. It also generates `osd_active`, held for a programmable number of frames counted on `vblank` rising edges. The overlay reads the same RAM on port B.

Parameters:
SCREEN_COLS, 48, characters per row
SCREEN_ROWS, 32, character rows
ADDR_W, 11, character RAM address width (covers 1536 cells)
TIMER_W, 10, width of frame-count timer

Ports:
clk  in  1  master clock (32 MHz)
reset_n  in  1  asynchronous active-low reset
vblank  in  1  vertical blank, synchronous to clk
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=CLEAR, 1=SETPOS, 2=PUTC, 3=SHOW
cmd_arg  in  11  operand (see Behaviour)
addr_a  out  ADDR_W  character RAM write address
data_a  out  8  character RAM write data
we_a  out  1  character RAM write enable
osd_active  out  1  OSD visible flag to the overlay
busy  out  1  high while a CLEAR is in progress

Behaviour:
- Reset values (async, reset_n low):
  - State IDLE; cursor row=0, col=0; timer=0.
  - addr_a=0, data_a=0, we_a=0, osd_active=0, busy=0.
  - cmd_ready=1 once reset_n is released.
- cmd_ready = (state==IDLE), combinational from state. All other outputs are registered.
- Accept cycle N (cmd_valid && cmd_ready) actions:
  - CLEAR: fill = cmd_arg[7:0]; state->CLEAR at N+1.
    - we_a=1 with addr_a=0..1535 consecutively on N+1..N+1536.
    - busy=1 over N+1..N+1536; state IDLE at N+1537.
    - Cursor is reset to (0,0).
  - SETPOS: row = cmd_arg[10:6] (5 bits), col = cmd_arg[5:0]. A col value of 48..63 saturates to 47. No RAM write.
  - PUTC: at N+1, we_a=1, addr_a=row*48+col, data_a=cmd_arg[7:0]. Then the cursor advances:
    - col+1.
    - At col 47, col wraps to 0 and row increments.
    - At (31,47), the cursor wraps to (0,0).
    - Throughput: one PUTC per cycle.
  - SHOW: timer <= cmd_arg[TIMER_W-1:0] at N+1.
    - arg=0 drops osd_active at N+2.
    - SHOW while the timer is running reloads it (no accumulation).
- we_a is high for exactly one cycle per PUTC, and for 1536 cycles per CLEAR. It is 0 at all other times.
- When we_a=0, addr_a and data_a hold their last values.
- Address arithmetic: row*48+col, computed as (row<<5)+(row<<4)+col at ADDR_W bits. Maximum value is 1535, with no overflow.
- Timer:
  - Rising edge of vblank = vblank && !vblank_d, with vblank_d registered.
  - On each rising edge with timer>0, timer decrements.
  - osd_active = (timer != 0), registered (one cycle after timer update).
  - A SHOW load in the same cycle as a vblank edge: the load wins, no decrement that cycle.
  - The timer runs independently of the write state machine; it counts during CLEAR.
- Commands presented during CLEAR are stalled (cmd_ready=0), not dropped.
- cmd_op/cmd_arg are sampled only on the accept cycle.
- reset_n asserted mid-CLEAR: outputs go to reset values immediately and the fill is abandoned. RAM contents are partial and left as-is.

Decomposition:
- Package osd_pkg:
  - SCREEN_COLS, SCREEN_ROWS, OSD_CELLS (=1536), ADDR_W.
  - typedef enum logic [1:0] osd_op_t {OSD_CLEAR, OSD_SETPOS, OSD_PUTC, OSD_SHOW}.
  - typedef enum state_t {ST_IDLE, ST_CLEAR}.
- Sub-module osd_frame_timer: vblank edge detect, loadable down-counter, osd_active output.
- The write FSM and cursor stay in osd_text_writer.

Test Plan:
- Reset release: we_a=0, osd_active=0, cmd_ready=1, addr_a=0. Assert reset_n low mid-run -> all outputs reset asynchronously (same cycle, before the next clk edge).
- CLEAR arg=0x20 accepted at cycle N -> we_a=1 N+1..N+1536, addr_a 0..1535 monotonic, data_a=0x20, busy=1, cmd_ready=0. PUTC held valid during the fill is accepted at N+1537.
- SETPOS {row=2,col=46} then PUTC 'A','B','C' back-to-back -> writes (addr,data): (142,0x41), (143,0x42), (144,0x43). Cursor ends at (3,1).
- SETPOS {row=31,col=47}, PUTC 0x58 -> write at addr 1535. Next PUTC writes addr 0. SETPOS col=60 on row 0 -> next write at addr 47.
- SHOW 3 -> osd_active=1; stays high across 2 vblank rising edges; low one cycle after the 3rd edge. A held-high vblank counts once per edge.
- SHOW 5 accepted in the same cycle as a vblank edge -> timer=5, not 4. SHOW 0 while active -> osd_active=0 at N+2.
